// File: rtl/pipes_pkg.sv
// Shared pipeline types: M-extension op encoding, sequencer states,
// iteration count, and small op-classification / decode helpers.
package pipes_pkg;

  localparam int MULDIV_ITERS = 64;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_OP32 = 7'b0111011;

  typedef enum logic [3:0] {
    OP_MUL   = 4'd0,
    OP_MULW  = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_REM   = 4'd4,
    OP_REMU  = 4'd5,
    OP_DIVW  = 4'd6,
    OP_DIVUW = 4'd7,
    OP_REMW  = 4'd8,
    OP_REMUW = 4'd9
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } muldiv_state_t;

  // Maps opcode/funct3 of an M-extension instruction to the sequencer op.
  // MULH* encodings are outside this subset and fall back to MUL/MULW.
  function automatic muldiv_op_t decode_muldiv(input logic [6:0] opcode,
                                               input logic [2:0] funct3);
    muldiv_op_t res;
    logic       w;
    w = (opcode == OPC_OP32);
    case (funct3)
      3'b100:  res = w ? OP_DIVW  : OP_DIV;
      3'b101:  res = w ? OP_DIVUW : OP_DIVU;
      3'b110:  res = w ? OP_REMW  : OP_REM;
      3'b111:  res = w ? OP_REMUW : OP_REMU;
      default: res = w ? OP_MULW  : OP_MUL;
    endcase
    return res;
  endfunction

  function automatic logic op_is_w(input muldiv_op_t o);
    return (o == OP_MULW) || (o == OP_DIVW) || (o == OP_DIVUW) ||
           (o == OP_REMW) || (o == OP_REMUW);
  endfunction

  function automatic logic op_is_mul(input muldiv_op_t o);
    return (o == OP_MUL) || (o == OP_MULW);
  endfunction

  // Signed here means the 32-bit operands are sign-extended.
  function automatic logic op_is_signed(input muldiv_op_t o);
    return (o == OP_MULW) || (o == OP_DIV) || (o == OP_REM) ||
           (o == OP_DIVW) || (o == OP_REMW);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t o);
    return (o == OP_REM) || (o == OP_REMU) || (o == OP_REMW) || (o == OP_REMUW);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single combinational step of the shared iterative unit.
// Multiply: acc += opa when the current multiplier bit (opb[0]) is set,
//           then multiplicand shifts left and multiplier shifts right.
// Divide:   restoring step; opa holds dividend bits shifting out of the top
//           and quotient bits shifting in at the bottom, acc holds the
//           partial remainder, opb is the divisor.
module muldiv_iter #(
  parameter int CNT_W = 6
) (
  input  logic             is_div_i,
  input  logic [63:0]      acc_i,
  input  logic [63:0]      opa_i,
  input  logic [63:0]      opb_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [63:0]      acc_o,
  output logic [63:0]      opa_o,
  output logic [63:0]      opb_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [64:0] rem_shift;
  logic        ge;

  // One shift-add or restoring-subtract step plus counter advance.
  always_comb begin
    rem_shift = {acc_i, opa_i[63]};
    ge        = (rem_shift >= {1'b0, opb_i});
    cnt_o     = cnt_i + 1'b1;
    if (is_div_i) begin
      // When ge holds the difference is below the divisor, so 64 bits suffice.
      acc_o = ge ? (rem_shift[63:0] - opb_i) : rem_shift[63:0];
      opa_o = {opa_i[62:0], ge};
      opb_o = opb_i;
    end else begin
      acc_o = acc_i + (opb_i[0] ? opa_i : 64'd0);
      opa_o = {opa_i[62:0], 1'b0};
      opb_o = {1'b0, opb_i[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV64M multiply/divide sequencer. Accepts one instruction from
// execute, iterates the shared unit ITERS times, applies sign/W fixups and
// presents a registered result with a one-cycle result_valid pulse.
//
// Handshake: an instruction is accepted on a clock edge where
// valid_in && ready && !flush. valid_in must stay high until the cycle in
// which result_valid pulses; stall holds execute meanwhile. The valid_in
// seen in the DONE cycle belongs to the finishing instruction. flush kills
// whatever is in flight at the next edge and suppresses result_valid.
module muldiv_ctrl
  import pipes_pkg::*;
#(
  parameter int ITERS = MULDIV_ITERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  muldiv_op_t  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        stall,
  output logic        result_valid,
  output logic [63:0] result,
  output logic [2:0]  dbg_state
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      opa_q, opa_d;
  logic [63:0]      opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [63:0]      result_q, result_d;

  logic             in_w, in_sgn, in_mul, in_rem, in_sdiv;
  logic [63:0]      prep_a, prep_b, abs_a, abs_b;
  logic             div_zero, div_ovf;
  logic [63:0]      special_raw, special_res;

  logic [63:0]      quo_val, rem_val, sel_val, fix_res;

  logic [63:0]      it_acc, it_opa, it_opb;
  logic [CNT_W-1:0] it_cnt;

  muldiv_iter #(.CNT_W(CNT_W)) u_iter (
    .is_div_i (state_q == S_DIV),
    .acc_i    (acc_q),
    .opa_i    (opa_q),
    .opb_i    (opb_q),
    .cnt_i    (cnt_q),
    .acc_o    (it_acc),
    .opa_o    (it_opa),
    .opb_o    (it_opb),
    .cnt_o    (it_cnt)
  );

  // Operand preparation and special-case detection for the presented instruction.
  always_comb begin
    in_w   = op_is_w(op);
    in_sgn = op_is_signed(op);
    in_mul = op_is_mul(op);
    in_rem = op_is_rem(op);
    prep_a = a;
    prep_b = b;
    if (in_w) begin
      prep_a = in_sgn ? sext32(a[31:0]) : {32'd0, a[31:0]};
      prep_b = in_sgn ? sext32(b[31:0]) : {32'd0, b[31:0]};
    end
    in_sdiv  = in_sgn && !in_mul;
    abs_a    = (in_sdiv && prep_a[63]) ? -prep_a : prep_a;
    abs_b    = (in_sdiv && prep_b[63]) ? -prep_b : prep_b;
    div_zero = !in_mul && (prep_b == 64'd0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (div_zero) special_raw = in_rem ? prep_a : 64'hFFFF_FFFF_FFFF_FFFF;
    else          special_raw = in_rem ? 64'd0  : prep_a;
    special_res = in_w ? sext32(special_raw[31:0]) : special_raw;
  end

  // Final sign correction and quotient/remainder/product selection.
  always_comb begin
    quo_val = neg_quo_q ? -opa_q : opa_q;
    rem_val = neg_rem_q ? -acc_q : acc_q;
    if (op_is_mul(op_q))      sel_val = acc_q;
    else if (op_is_rem(op_q)) sel_val = rem_val;
    else                      sel_val = quo_val;
    fix_res = op_is_w(op_q) ? sext32(sel_val[31:0]) : sel_val;
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    acc_d        = acc_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cnt_d        = cnt_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    result_d     = result_q;
    ready        = (state_q == S_IDLE);
    result_valid = (state_q == S_DONE) && !flush;
    stall        = valid_in && !result_valid && !flush;
    case (state_q)
      S_IDLE: begin
        if (valid_in && !flush) begin
          op_d      = op;
          acc_d     = 64'd0;
          cnt_d     = '0;
          opa_d     = abs_a;
          opb_d     = abs_b;
          neg_quo_d = in_sdiv && (prep_a[63] ^ prep_b[63]);
          neg_rem_d = in_sdiv && prep_a[63];
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = in_mul ? S_MUL : S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = it_acc;
        opa_d = it_opa;
        opb_d = it_opb;
        cnt_d = it_cnt;
        if (cnt_q == CNT_LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A killed instruction must leave no trace on the visible result.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers; reset returns to IDLE from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      acc_q     <= 64'd0;
      opa_q     <= 64'd0;
      opb_q     <= 64'd0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
